// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// Module : mem_access_stage_pkg
// Brief  : Opcodes, FSM state type and lane/extend helpers for the MEM stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [31:0] DEADBEEF_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] a);
    logic [3:0] be;
    case (op)
      OP_LB, OP_LBU, OP_SB: be = 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: be = a[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   v = {{24{b[7]}}, b};
      OP_LBU:  v = {24'h0, b};
      OP_LH:   v = {{16{h[15]}}, h};
      OP_LHU:  v = {16'h0, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    logic m;
    case (op)
      OP_LH, OP_LHU, OP_SH: m = a[0];
      OP_LW, OP_SW:         m = |a;
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module : mem_lane_align
// Brief  : Combinational byte-enable, store replication and load extension.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  always_comb begin
    be_o   = lane_be(op_i, addr_lo_i);
    load_o = load_extend(op_i, addr_lo_i, rdata_i);
    case (op_i)
      OP_SB:   wdata_o = {4{rt_i[7:0]}};
      OP_SH:   wdata_o = {2{rt_i[15:0]}};
      default: wdata_o = rt_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM pipeline stage; variable-latency data-memory port with timeout.
//          Optional MEM_ALIGN_CHECK_EN aborts misaligned accesses before request.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Wdata,
  output logic        mem_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       rt_q, rt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0]        w_in_op;
  logic              w_misalign;
  logic [3:0]        w_be;
  logic [31:0]       w_load;
  logic              w_unused_ins;

  assign w_in_op      = Ins[31:26];
  assign w_unused_ins = ^Ins[25:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = misaligned(w_in_op, Result[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  mem_lane_align u_lane (
    .op_i      (op_q),
    .addr_lo_i (result_q[1:0]),
    .rt_i      (rt_q),
    .rdata_i   (dmem_rdata),
    .be_o      (w_be),
    .wdata_o   (dmem_wdata),
    .load_o    (w_load)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    rt_d     = rt_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d     = w_in_op;
          result_d = Result;
          rt_d     = Rdata2;
          err_d    = 1'b0;
          if (!(is_load(w_in_op) || is_store(w_in_op))) begin
            wdata_d = Result;
            state_d = ST_RESP;
          end else if (w_misalign) begin
            wdata_d = Result;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (is_store(op_q)) begin
            wdata_d = result_q;
            state_d = ST_RESP;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          wdata_d = w_load;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          wdata_d = DEADBEEF_WORD;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // RESP returns to IDLE without accepting in the same cycle
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      rt_q     <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      rt_q     <= rt_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign dmem_req  = (state_q == ST_REQ);
  assign dmem_we   = dmem_req && is_store(op_q);
  assign dmem_be   = dmem_req ? w_be : 4'b0000;
  assign dmem_addr = {result_q[31:2], 2'b00};
  assign out_valid = (state_q == ST_RESP);
  assign Wdata     = wdata_q;
  assign mem_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Directed self-checking bench for mem_access_stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Ins = '0;
  logic [31:0] Result = '0;
  logic [31:0] Rdata2 = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Wdata;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .Wdata(Wdata), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rt);
    in_valid = 1'b1; Ins = {op, 26'h0}; Result = res; Rdata2 = rt;
    step();
    in_valid = 1'b0;
  endtask

  task automatic grant();
    dmem_gnt = 1'b1; step(); dmem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    dmem_rvalid = 1'b1; dmem_rdata = d; step(); dmem_rvalid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #3;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin n_bad++; $display("FAIL rst_dmem got %b want 000000", {dmem_req, dmem_we, dmem_be}); end
    n_cmp++; if ({out_valid, mem_err} !== 2'b00) begin n_bad++; $display("FAIL rst_out got %b want 00", {out_valid, mem_err}); end
    n_cmp++; if (Wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 00000000", Wdata); end
    step(); step();
    RST = 1'b1;
    step();
  endtask

  task automatic test_lw();
    issue(6'h23, 32'h100, 32'h0);
    n_cmp++; if ({dmem_req, dmem_we, dmem_be} !== 6'b101111) begin n_bad++; $display("FAIL lw_req got %b want 101111", {dmem_req, dmem_we, dmem_be}); end
    n_cmp++; if (dmem_addr !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h want 00000100", dmem_addr); end
    step();
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin n_bad++; $display("FAIL lw_req_hold got %b/%h want 1/00000100", dmem_req, dmem_addr); end
    grant();
    n_cmp++; if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_wait got req %b ov %b want 0 0", dmem_req, out_valid); end
    step(); step();
    respond(32'h12345678);
    n_cmp++; if (out_valid !== 1'b1 || mem_err !== 1'b0) begin n_bad++; $display("FAIL lw_resp got ov %b err %b want 1 0", out_valid, mem_err); end
    n_cmp++; if (Wdata !== 32'h12345678) begin n_bad++; $display("FAIL lw_wdata got %h want 12345678", Wdata); end
    release_out();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_idle got ir %b ov %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_lb();
    issue(6'h20, 32'h103, 32'h0);
    n_cmp++; if (dmem_be !== 4'b1000 || dmem_addr !== 32'h100) begin n_bad++; $display("FAIL lb_be got %b/%h want 1000/00000100", dmem_be, dmem_addr); end
    grant();
    respond(32'h80FF0000);
    n_cmp++; if (Wdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_wdata got %h want ffffff80", Wdata); end
    release_out();
    issue(6'h24, 32'h103, 32'h0);
    grant();
    respond(32'h80FF0000);
    n_cmp++; if (Wdata !== 32'h00000080) begin n_bad++; $display("FAIL lbu_wdata got %h want 00000080", Wdata); end
    release_out();
    issue(6'h21, 32'h102, 32'h0);
    grant();
    respond(32'h8001_7FFF);
    n_cmp++; if (Wdata !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_wdata got %h want ffff8001", Wdata); end
    release_out();
  endtask

  task automatic test_sh();
    issue(6'h29, 32'h202, 32'h0000BEEF);
    n_cmp++; if ({dmem_req, dmem_we, dmem_be} !== 6'b111100) begin n_bad++; $display("FAIL sh_req got %b want 111100", {dmem_req, dmem_we, dmem_be}); end
    n_cmp++; if (dmem_wdata !== 32'hBEEFBEEF || dmem_addr !== 32'h200) begin n_bad++; $display("FAIL sh_data got %h/%h want beefbeef/00000200", dmem_wdata, dmem_addr); end
    grant();
    n_cmp++; if (out_valid !== 1'b1 || Wdata !== 32'h202 || mem_err !== 1'b0) begin n_bad++; $display("FAIL sh_resp got %b %h %b want 1 00000202 0", out_valid, Wdata, mem_err); end
    release_out();
    issue(6'h28, 32'h301, 32'h000000A5);
    n_cmp++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_lane got %b/%h want 0010/a5a5a5a5", dmem_be, dmem_wdata); end
    grant();
    release_out();
  endtask

  task automatic test_add();
    issue(6'h00, 32'h7, 32'h0);
    n_cmp++; if (out_valid !== 1'b1 || dmem_req !== 1'b0 || Wdata !== 32'h7) begin n_bad++; $display("FAIL add_resp got %b %b %h want 1 0 00000007", out_valid, dmem_req, Wdata); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (Wdata !== 32'h7 || in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL add_hold[%0d] got %h ir %b ov %b want 00000007 0 1", i, Wdata, in_ready, out_valid); end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    issue(6'h00, 32'h5, 32'h0);
    in_valid = 1'b1; Ins = 32'h0; Result = 32'h9;
    step();
    n_cmp++; if (Wdata !== 32'h5 || in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %h ir %b want 00000005 0", Wdata, in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap got ov %b ir %b want 0 1", out_valid, in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || Wdata !== 32'h9) begin n_bad++; $display("FAIL b2b_second got %b %h want 1 00000009", out_valid, Wdata); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle got %b want 1", in_ready); end
  endtask

  task automatic test_timeout();
    int n;
    issue(6'h23, 32'h300, 32'h0);
    grant();
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_cmp++; if (n != TO) begin n_bad++; $display("FAIL to_cycles got %0d want %0d", n, TO); end
    n_cmp++; if (mem_err !== 1'b1 || Wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL to_resp got %b %h want 1 deadbeef", mem_err, Wdata); end
    release_out();
  endtask

  task automatic test_reset_in_req();
    issue(6'h23, 32'h400, 32'h0);
    n_cmp++; if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL rreq_pre got %b want 1", dmem_req); end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rreq_async got req %b ir %b want 0 1", dmem_req, in_ready); end
    step();
    RST = 1'b1;
    grant();
    n_cmp++; if (dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rreq_late_gnt got %b %b %b want 0 0 1", dmem_req, out_valid, in_ready); end
    respond(32'h11111111);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rreq_late_rv got ov %b ir %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_misalign();
    issue(6'h23, 32'h101, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    n_cmp++; if (dmem_req !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mis_skip got req %b ov %b want 0 1", dmem_req, out_valid); end
    n_cmp++; if (mem_err !== 1'b1 || Wdata !== 32'h101) begin n_bad++; $display("FAIL mis_err got %b %h want 1 00000101", mem_err, Wdata); end
    release_out();
`else
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin n_bad++; $display("FAIL mis_req got %b %h %b want 1 00000100 1111", dmem_req, dmem_addr, dmem_be); end
    grant();
    respond(32'hCAFEF00D);
    n_cmp++; if (mem_err !== 1'b0 || Wdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL mis_data got %b %h want 0 cafef00d", mem_err, Wdata); end
    release_out();
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_add();
    test_back_to_back();
    test_timeout();
    test_reset_in_req();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
